// File: rtl/mem_bus_arbiter.sv
// Unified memory bus arbiter for the IF fetch port and the MM data port.
// Data has priority; a streak limit and a per-transaction timeout bound every wait.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [INST_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  bus_err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(MAX_D_STREAK);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] t_cnt;
    logic [SW-1:0] streak;
    logic          d_pend;
    logic          d_win;
    logic          rdy_hold;
    logic          timed_out;
    logic          done;

    always_comb begin
        d_pend    = d_read | d_write;
        d_win     = d_pend && (!i_req || (streak < S_MAX));
        // The ready cycle is a dead cycle so the requester can update its request.
        rdy_hold  = i_ready | d_ready;
        timed_out = !bus_ack && (t_cnt == T_LAST);
        done      = bus_ack || timed_out;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            t_cnt     <= '0;
            streak    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rdy_hold) begin
                        if (d_win) begin
                            state     <= GNT_D;
                            bus_req   <= 1'b1;
                            bus_we    <= d_write;
                            bus_addr  <= d_addr;
                            bus_wdata <= d_wdata;
                        end else if (i_req) begin
                            state     <= GNT_I;
                            bus_req   <= 1'b1;
                            bus_we    <= 1'b0;
                            bus_addr  <= i_addr;
                            bus_wdata <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (done) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        t_cnt   <= '0;
                        bus_err <= timed_out;
                        if (state == GNT_I) begin
                            i_ready <= 1'b1;
                            i_rdata <= timed_out ? '0 : bus_rdata[INST_WIDTH-1:0];
                            streak  <= '0;
                        end else begin
                            d_ready <= 1'b1;
                            d_rdata <= timed_out ? '0 : bus_rdata;
                            if (!i_req)
                                streak <= '0;
                            else if (streak != S_MAX)
                                streak <= streak + 1'b1;
                        end
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;
    localparam int MS = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [IW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic          bus_err;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_WIDTH(IW),
        .MAX_D_STREAK(MS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({bus_req, bus_we, i_ready, d_ready, bus_err, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus_req, bus_we, i_ready, d_ready, bus_err, busy});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata, i_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h ird=%h drd=%h expected all 0",
                     bus_addr, bus_wdata, i_rdata, d_rdata);
        end
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if ({bus_req, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b expected 00", {bus_req, busy});
        end
    endtask

    task automatic test_fetch;
        i_req  = 1'b1;
        i_addr = 64'h100;
        tick;
        n_cmp++;
        if ({bus_req, bus_we, busy, i_ready, bus_addr} !== {4'b1010, 64'h100}) begin
            n_bad++;
            $display("FAIL fetch_issue: got req/we/busy/rdy=%b addr=%h expected 1010 addr=100",
                     {bus_req, bus_we, busy, i_ready}, bus_addr);
        end
        bus_ack   = 1'b1;
        bus_rdata = 64'hABCD_EF01_0000_0013;
        tick;
        bus_ack = 1'b0;
        n_cmp++;
        if ({i_ready, d_ready, bus_req, busy, bus_err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL fetch_done: got %b expected 10000",
                     {i_ready, d_ready, bus_req, busy, bus_err});
        end
        n_cmp++;
        if (i_rdata !== 32'h0000_0013) begin
            n_bad++;
            $display("FAIL fetch_data: got %h expected 00000013", i_rdata);
        end
        i_req = 1'b0;
        tick;
        n_cmp++;
        if (i_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_pulse: got %b expected 0", i_ready);
        end
    endtask

    task automatic test_store;
        int w;
        w       = $urandom_range(1, 5);
        d_write = 1'b1;
        d_addr  = 64'h2000;
        d_wdata = 64'hDEAD_BEEF;
        tick;
        for (int k = 0; k < w; k++) begin
            n_cmp++;
            if ({bus_req, bus_we, d_ready, bus_addr, bus_wdata} !==
                {3'b110, 64'h2000, 64'hDEAD_BEEF}) begin
                n_bad++;
                $display("FAIL store_hold: got req/we/rdy=%b addr=%h wdata=%h expected 110 2000 deadbeef",
                         {bus_req, bus_we, d_ready}, bus_addr, bus_wdata);
            end
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
            if (k == w - 1) bus_ack = 1'b1;
            tick;
        end
        bus_ack = 1'b0;
        n_cmp++;
        if ({d_ready, i_ready, bus_err, busy, bus_req} !== 5'b10000) begin
            n_bad++;
            $display("FAIL store_done: got %b expected 10000",
                     {d_ready, i_ready, bus_err, busy, bus_req});
        end
        d_write = 1'b0;
        tick;
        n_cmp++;
        if (d_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL store_pulse: got %b expected 0", d_ready);
        end
    endtask

    task automatic test_starvation;
        byte exp_seq [10];
        byte got_seq [10];
        int  s;
        int  grants;
        int  ri;
        int  rd;
        s = 0;
        for (int n = 0; n < 10; n++) begin
            if (s < MS) begin
                exp_seq[n] = "D";
                s++;
            end else begin
                exp_seq[n] = "I";
                s = 0;
            end
            got_seq[n] = "?";
        end
        grants = 0;
        ri     = 0;
        rd     = 0;
        i_req  = 1'b1;
        i_addr = 64'h100;
        d_read = 1'b1;
        d_addr = 64'h2000;
        for (int c = 0; c < 300 && (ri + rd) < 10; c++) begin
            tick;
            if (i_ready && d_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL starve_both_ready: got i_ready=1 d_ready=1 expected one-hot");
            end
            if (i_ready) ri++;
            if (d_ready) rd++;
            if ((ri + rd) == 10) begin
                i_req  = 1'b0;
                d_read = 1'b0;
            end
            if (bus_req && !bus_ack && grants < 10) begin
                got_seq[grants] = (bus_addr == 64'h2000) ? "D" : "I";
                grants++;
                bus_ack   = 1'b1;
                bus_rdata = {$urandom, $urandom};
            end else begin
                bus_ack = 1'b0;
            end
        end
        bus_ack = 1'b0;
        i_req   = 1'b0;
        d_read  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            n_cmp++;
            if (got_seq[n] !== exp_seq[n]) begin
                n_bad++;
                $display("FAIL starve_grant_%0d: got %c expected %c", n, got_seq[n], exp_seq[n]);
            end
        end
        n_cmp++;
        if (ri != 2 || rd != 8) begin
            n_bad++;
            $display("FAIL starve_readies: got i=%0d d=%0d expected i=2 d=8", ri, rd);
        end
        tick;
        tick;
    endtask

    task automatic test_timeout;
        d_read    = 1'b1;
        d_addr    = 64'h3000;
        bus_rdata = 64'h1234_5678_9ABC_DEF0;
        tick;
        for (int k = 0; k < TO - 1; k++) begin
            tick;
            n_cmp++;
            if ({bus_req, d_ready, bus_err} !== 3'b100) begin
                n_bad++;
                $display("FAIL timeout_wait_%0d: got %b expected 100", k, {bus_req, d_ready, bus_err});
            end
        end
        tick;
        n_cmp++;
        if ({bus_req, d_ready, bus_err, i_ready, d_rdata} !== {4'b0110, 64'h0}) begin
            n_bad++;
            $display("FAIL timeout_abort: got req/rdy/err/irdy=%b rdata=%h expected 0110 0",
                     {bus_req, d_ready, bus_err, i_ready}, d_rdata);
        end
        d_read = 1'b0;
        tick;
        n_cmp++;
        if ({d_ready, bus_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_pulse: got %b expected 00", {d_ready, bus_err});
        end
        bus_ack = 1'b1;
        tick;
        bus_ack = 1'b0;
        n_cmp++;
        if ({i_ready, d_ready, bus_err, busy, bus_req} !== 5'b0) begin
            n_bad++;
            $display("FAIL late_ack: got %b expected 00000",
                     {i_ready, d_ready, bus_err, busy, bus_req});
        end
        tick;
    endtask

    task automatic test_ack_boundary;
        logic [DW-1:0] v;
        v      = {$urandom, $urandom};
        d_read = 1'b1;
        d_addr = 64'h3008;
        tick;
        for (int k = 0; k < TO - 1; k++) tick;
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_bad++;
            $display("FAIL boundary_wait: got bus_req=%b expected 1", bus_req);
        end
        bus_ack   = 1'b1;
        bus_rdata = v;
        tick;
        bus_ack = 1'b0;
        n_cmp++;
        if ({d_ready, bus_err, bus_req} !== 3'b100 || d_rdata !== v) begin
            n_bad++;
            $display("FAIL boundary_ack: got rdy/err/req=%b rdata=%h expected 100 rdata=%h",
                     {d_ready, bus_err, bus_req}, d_rdata, v);
        end
        d_read = 1'b0;
        tick;
    endtask

    task automatic test_mid_reset;
        i_req  = 1'b1;
        i_addr = 64'h400;
        tick;
        n_cmp++;
        if ({bus_req, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL midrst_grant: got %b expected 11", {bus_req, busy});
        end
        rst_n = 1'b0;
        i_req = 1'b0;
        tick;
        rst_n     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = {$urandom, $urandom};
        tick;
        bus_ack = 1'b0;
        n_cmp++;
        if ({bus_req, bus_we, i_ready, d_ready, bus_err, busy} !== 6'b0 ||
            {bus_addr, bus_wdata, i_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got ctrl=%b addr=%h ird=%h expected 0",
                     {bus_req, bus_we, i_ready, d_ready, bus_err, busy}, bus_addr, i_rdata);
        end
        tick;
        n_cmp++;
        if (i_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_no_ready: got %b expected 0", i_ready);
        end
    endtask

    task automatic test_random;
        int            own;
        int            wc;
        int            lat;
        int            streak;
        int            n_txn;
        int            op;
        bit            arb_ok;
        bit            done_n;
        bit            err_n;
        bit            was_done;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_data;
        logic [IW-1:0] exp_inst;
        own = 0; wc = 0; lat = 0; streak = 0; n_txn = 0;
        arb_ok = 1'b1; done_n = 1'b0; err_n = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_data = '0;
        for (int c = 0; c < 4000; c++) begin
            tick;
            was_done = done_n;
            if (done_n) begin
                n_cmp++;
                if ({i_ready, d_ready, bus_err, bus_req} !== {own == 1, own == 2, err_n, 1'b0}) begin
                    n_bad++;
                    $display("FAIL rand_done: got rdy_i/rdy_d/err/req=%b expected %b",
                             {i_ready, d_ready, bus_err, bus_req},
                             {own == 1, own == 2, err_n, 1'b0});
                end
                n_cmp++;
                exp_inst = exp_data[IW-1:0];
                if ((own == 1 && i_rdata !== exp_inst) || (own == 2 && d_rdata !== exp_data)) begin
                    n_bad++;
                    $display("FAIL rand_data: got i=%h d=%h expected %h", i_rdata, d_rdata, exp_data);
                end
                if (own == 2)
                    streak = i_req ? ((streak < MS) ? streak + 1 : MS) : 0;
                else
                    streak = 0;
                if (own == 1) begin
                    i_req = 1'b0;
                end else begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
                own = 0;
                n_txn++;
            end else begin
                n_cmp++;
                if ({i_ready, d_ready, bus_err} !== 3'b000) begin
                    n_bad++;
                    $display("FAIL rand_quiet: got %b expected 000", {i_ready, d_ready, bus_err});
                end
                if (own != 0) begin
                    wc++;
                end else if (arb_ok && (i_req || d_read || d_write)) begin
                    own       = ((d_read || d_write) && (!i_req || streak < MS)) ? 2 : 1;
                    exp_we    = (own == 2) ? d_write : 1'b0;
                    exp_addr  = (own == 2) ? d_addr : i_addr;
                    exp_wdata = (own == 2) ? d_wdata : '0;
                    wc        = 1;
                    lat       = $urandom_range(1, TO + 2);
                end
                n_cmp++;
                if (own != 0) begin
                    if ({bus_req, bus_we, busy, bus_addr, bus_wdata} !==
                        {1'b1, exp_we, 1'b1, exp_addr, exp_wdata}) begin
                        n_bad++;
                        $display("FAIL rand_bus: got req/we/busy=%b addr=%h wd=%h expected 1%b1 addr=%h wd=%h",
                                 {bus_req, bus_we, busy}, bus_addr, bus_wdata,
                                 exp_we, exp_addr, exp_wdata);
                    end
                end else if ({bus_req, busy} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rand_idle: got req/busy=%b expected 00", {bus_req, busy});
                end
            end
            arb_ok = (own == 0) && !was_done;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = {$urandom, $urandom};
            end
            if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                op      = $urandom_range(0, 2);
                d_read  = (op != 1);
                d_write = (op != 0);
                d_addr  = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
            end
            bus_rdata = {$urandom, $urandom};
            if (own != 0) begin
                bus_ack  = (wc == lat);
                done_n   = bus_ack || (wc == TO);
                err_n    = !bus_ack;
                exp_data = bus_ack ? bus_rdata : '0;
            end else begin
                bus_ack = ($urandom_range(0, 7) == 0);
                done_n  = 1'b0;
            end
        end
        bus_ack = 1'b0;
        i_req   = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        n_cmp++;
        if (n_txn < 50) begin
            n_bad++;
            $display("FAIL rand_progress: got %0d transactions expected at least 50", n_txn);
        end
        for (int k = 0; k < TO + 4; k++) tick;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store;
        test_starvation;
        test_timeout;
        test_ack_boundary;
        test_mid_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified memory bus between the instruction-fetch port (IF stage) and the data port (MM stage) of the 5-stage core.
- Data accesses have priority over fetches. A starvation counter forces an instruction grant after a bounded number of back-to-back data grants.
- A per-transaction timeout counter guarantees that every accepted request completes, either normally or with an error.
- Sits between cpu_top's imem/dmem interfaces and the external memory.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data bus width.
- INST_WIDTH, 32, instruction width; fetch data is taken from bus_rdata[INST_WIDTH-1:0].
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1).
- TIMEOUT, 255, cycles to wait for bus_ack before aborting (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_rdata  out  INST_WIDTH  fetched instruction.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_read  in  1  data load request; held until d_ready.
- d_write  in  1  data store request; held until d_ready.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data.
- d_ready  out  1  one-cycle data completion pulse.
- bus_req  out  1  bus transaction valid (registered).
- bus_we  out  1  1 = write (registered).
- bus_addr  out  ADDR_WIDTH  bus address (registered).
- bus_wdata  out  DATA_WIDTH  bus write data (registered).
- bus_rdata  in  DATA_WIDTH  bus read data; valid when bus_ack=1.
- bus_ack  in  1  bus completion; one-cycle pulse.
- bus_err  out  1  one-cycle pulse when a transaction is aborted on timeout.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; bus_req, bus_we, i_ready, d_ready, bus_err, busy = 0.
  - bus_addr, bus_wdata, i_rdata, d_rdata = 0; streak counter and timeout counter = 0.
  - Reset asserted mid-transaction abandons it immediately: no ready pulse, and a bus_ack arriving after reset is ignored.
- Request decode:
  - d_pend = d_read | d_write. If both are high, it is treated as a write (bus_we=1).
- States: IDLE, GNT_I, GNT_D.
- IDLE arbitration, evaluated each cycle:
  - If d_pend and (!i_req or streak < MAX_D_STREAK): go to GNT_D, bus_req<=1, bus_we<=d_write, bus_addr<=d_addr, bus_wdata<=d_wdata.
  - Else if i_req: go to GNT_I, bus_req<=1, bus_we<=0, bus_addr<=i_addr, bus_wdata<=0.
  - Else stay in IDLE.
  - bus_req therefore rises exactly one cycle after the request is first seen in IDLE.
- GNT_x, waiting for completion:
  - bus_req, bus_we, bus_addr and bus_wdata are held constant.
  - The timeout counter increments each cycle while bus_ack=0.
- On bus_ack=1 in GNT_x (same edge):
  - State goes to IDLE, bus_req<=0, timeout counter<=0.
  - The matching ready output pulses for exactly one cycle, in the cycle after the ack.
  - Read data is registered: i_rdata<=bus_rdata[INST_WIDTH-1:0] or d_rdata<=bus_rdata.
- Minimum transaction length is 3 cycles: request → bus_req → bus_ack → ready.
- After a ready pulse, the arbiter spends one cycle in IDLE before re-arbitrating. This lets the requester drop or update its request.
- Timeout:
  - When the counter reaches TIMEOUT with bus_ack still 0: go to IDLE, bus_req<=0.
  - bus_err and the owner's ready pulse together for one cycle; rdata is 0.
  - A late bus_ack received in IDLE is ignored.
- Streak counter:
  - On a GNT_D completion while i_req=1: increment, saturating at MAX_D_STREAK.
  - On any GNT_I completion, or when i_req=0 at a GNT_D completion: clear to 0.
- Simultaneous events:
  - bus_ack in the same cycle the counter reaches TIMEOUT is a normal completion; bus_err stays 0.
  - Request inputs changing while in GNT_x have no effect on the bus outputs.
- i_ready and d_ready are never high in the same cycle.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, bus_ack one cycle after bus_req with bus_rdata=0x00000013 → bus_req at t+1, ack at t+2, i_ready=1 at t+3 with i_rdata=0x00000013, busy deasserts at t+3.
- Store: d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF → bus_we=1, bus_addr=0x2000, bus_wdata=0xDEADBEEF, held until ack; then one d_ready pulse.
- Priority/starvation: i_req and d_read both held continuously, immediate acks, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; no two readies in the same cycle.
- Timeout: d_read=1, bus_ack never asserted, TIMEOUT=8 → after 8 waiting cycles, bus_req drops, d_ready=1 and bus_err=1 for one cycle, d_rdata=0; a later bus_ack produces no ready pulse.
- Ack at the timeout boundary: bus_ack on exactly the TIMEOUT-th waiting cycle → normal completion with bus_err=0 and valid data.
- Mid-transaction reset: rst_n=0 during GNT_I, then bus_ack after release → all outputs 0, state IDLE, no i_ready pulse.
